// File: rtl/instruction_decode_unit_if.sv
// Instruction decode stage bus: the fetch-side inputs and redirect/stall
// returns, the writeback port, the hazard inputs from EX/MEM, and the
// registered ID/EX bundle. The decode unit takes the slave side.
interface instruction_decode_unit_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) ();
    // fetch side
    logic [NB_DATA-1:0] i_instruction;
    logic [NB_ADDR-1:0] i_pc;
    logic               o_pc_source;
    logic [NB_DATA-1:0] o_branch_addr;
    logic               o_stall;

    // writeback port
    logic               i_wb_reg_write;
    logic [NB_REG-1:0]  i_wb_addr;
    logic [NB_DATA-1:0] i_wb_data;

    // downstream hazard information
    logic               i_ex_reg_write;
    logic               i_ex_mem_read;
    logic [NB_REG-1:0]  i_ex_dst;
    logic               i_mem_reg_write;
    logic [NB_REG-1:0]  i_mem_dst;

    // ID/EX bundle
    logic [NB_DATA-1:0] o_rs_data;
    logic [NB_DATA-1:0] o_rt_data;
    logic [NB_DATA-1:0] o_imm_ext;
    logic [NB_REG-1:0]  o_rs;
    logic [NB_REG-1:0]  o_rt;
    logic [NB_REG-1:0]  o_rd;
    logic [NB_ADDR-1:0] o_pc;
    logic               o_reg_write;
    logic               o_mem_read;
    logic               o_mem_write;
    logic               o_mem_to_reg;
    logic               o_alu_src;
    logic               o_reg_dst;
    logic [3:0]         o_alu_op;
    logic               o_halt;

    modport slave (
        input  i_instruction, i_pc,
        input  i_wb_reg_write, i_wb_addr, i_wb_data,
        input  i_ex_reg_write, i_ex_mem_read, i_ex_dst, i_mem_reg_write, i_mem_dst,
        output o_pc_source, o_branch_addr, o_stall,
        output o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_pc,
        output o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src,
        output o_reg_dst, o_alu_op, o_halt
    );

    modport master (
        output i_instruction, i_pc,
        output i_wb_reg_write, i_wb_addr, i_wb_data,
        output i_ex_reg_write, i_ex_mem_read, i_ex_dst, i_mem_reg_write, i_mem_dst,
        input  o_pc_source, o_branch_addr, o_stall,
        input  o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_pc,
        input  o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src,
        input  o_reg_dst, o_alu_op, o_halt
    );
endinterface

// File: rtl/instruction_decode_unit.sv
// Instruction decode stage: register file with writeback bypass, control
// decode, early BEQ/BNE resolution, load-use and branch-operand hazard
// stall, and the registered ID/EX bundle. Instruction word 0 is HALT.
module instruction_decode_unit #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    instruction_decode_unit_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;

    localparam int RF_DEPTH = 2 ** NB_REG;

    logic [NB_DATA-1:0] reg_file [RF_DEPTH];
    logic               valid_q;
    logic               flush_q;
    logic               halt_q;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  rd;
    logic [15:0]        imm16;
    logic [NB_DATA-1:0] imm_sext;
    logic [NB_DATA-1:0] imm_ext;
    logic [NB_DATA-1:0] rs_data;
    logic [NB_DATA-1:0] rt_data;

    logic               dec_known;
    logic               dec_reg_write;
    logic               dec_mem_read;
    logic               dec_mem_write;
    logic               dec_mem_to_reg;
    logic               dec_alu_src;
    logic               dec_reg_dst;
    logic [3:0]         dec_alu_op;
    logic               dec_imm_zero;
    logic               uses_rt;
    logic               is_beq;
    logic               is_bne;

    logic               is_halt;
    logic               squash;
    logic               load_use;
    logic               br_hazard;
    logic               stall;
    logic               active;
    logic               taken;
    logic               issue;

    assign opcode   = bus.i_instruction[31:26];
    assign funct    = bus.i_instruction[5:0];
    assign rs       = bus.i_instruction[21 +: NB_REG];
    assign rt       = bus.i_instruction[16 +: NB_REG];
    assign rd       = bus.i_instruction[11 +: NB_REG];
    assign imm16    = bus.i_instruction[15:0];
    assign imm_sext = {{(NB_DATA-16){imm16[15]}}, imm16};
    assign imm_ext  = dec_imm_zero ? {{(NB_DATA-16){1'b0}}, imm16} : imm_sext;
    assign is_halt  = (bus.i_instruction == '0);

    // Register file read with same-cycle writeback bypass; r0 is never written.
    always_comb begin
        rs_data = reg_file[rs];
        rt_data = reg_file[rt];
        if (bus.i_wb_reg_write && bus.i_wb_addr != '0 && bus.i_wb_addr == rs)
            rs_data = bus.i_wb_data;
        if (bus.i_wb_reg_write && bus.i_wb_addr != '0 && bus.i_wb_addr == rt)
            rt_data = bus.i_wb_data;
    end

    // Control decode from opcode/funct; unrecognised encodings leave dec_known low.
    always_comb begin
        dec_known      = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_alu_op     = ALU_ADD;
        dec_imm_zero   = 1'b0;
        uses_rt        = 1'b0;
        is_beq         = 1'b0;
        is_bne         = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt   = 1'b1;
                dec_known = 1'b1;
                case (funct)
                    FN_ADDU: dec_alu_op = ALU_ADD;
                    FN_SUBU: dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_OR:   dec_alu_op = ALU_OR;
                    FN_XOR:  dec_alu_op = ALU_XOR;
                    FN_SLT:  dec_alu_op = ALU_SLT;
                    default: dec_known  = 1'b0;
                endcase
                dec_reg_write = dec_known;
                dec_reg_dst   = dec_known;
            end
            OP_ADDI: begin
                dec_known     = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_ANDI: begin
                dec_known     = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_AND;
                dec_imm_zero  = 1'b1;
            end
            OP_ORI: begin
                dec_known     = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALU_OR;
                dec_imm_zero  = 1'b1;
            end
            OP_LW: begin
                dec_known      = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
            end
            OP_SW: begin
                dec_known     = 1'b1;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_BEQ: begin
                dec_known = 1'b1;
                is_beq    = 1'b1;
                uses_rt   = 1'b1;
            end
            OP_BNE: begin
                dec_known = 1'b1;
                is_bne    = 1'b1;
                uses_rt   = 1'b1;
            end
            default: ;
        endcase
    end

    // The first post-reset slot and the wrong-path slot after a taken branch
    // are squashed; squash beats stall, and stall beats branch and halt.
    assign squash    = !valid_q || flush_q;
    assign load_use  = bus.i_ex_mem_read && bus.i_ex_dst != '0 &&
                       (bus.i_ex_dst == rs || (uses_rt && bus.i_ex_dst == rt));
    assign br_hazard = (is_beq || is_bne) &&
                       ((bus.i_ex_reg_write && bus.i_ex_dst != '0 &&
                         (bus.i_ex_dst == rs || bus.i_ex_dst == rt)) ||
                        (bus.i_mem_reg_write && bus.i_mem_dst != '0 &&
                         (bus.i_mem_dst == rs || bus.i_mem_dst == rt)));
    assign stall     = !squash && (load_use || br_hazard);
    assign active    = !squash && !stall;
    assign taken     = active && ((is_beq && rs_data == rt_data) ||
                                  (is_bne && rs_data != rt_data));
    assign issue     = active && dec_known && !halt_q;

    // IF adds this to the branch's PC+2, so subtract one to land on PC+1+imm.
    assign bus.o_branch_addr = imm_sext - NB_DATA'(1);
    assign bus.o_pc_source   = taken;
    assign bus.o_stall       = stall;
    assign bus.o_halt        = halt_q;

    // Stage state: valid after reset, one-slot flush after a taken branch, sticky halt.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            flush_q <= taken;
            halt_q  <= halt_q || (active && is_halt);
        end
    end

    // Register file write port; cleared by reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < RF_DEPTH; i++)
                reg_file[i] <= '0;
        end else if (bus.i_wb_reg_write && bus.i_wb_addr != '0) begin
            reg_file[bus.i_wb_addr] <= bus.i_wb_data;
        end
    end

    // ID/EX bundle register; anything not issued goes out as an all-zero bubble.
    always_ff @(posedge i_clock) begin
        if (i_reset || !issue) begin
            bus.o_rs_data    <= '0;
            bus.o_rt_data    <= '0;
            bus.o_imm_ext    <= '0;
            bus.o_rs         <= '0;
            bus.o_rt         <= '0;
            bus.o_rd         <= '0;
            bus.o_pc         <= '0;
            bus.o_reg_write  <= 1'b0;
            bus.o_mem_read   <= 1'b0;
            bus.o_mem_write  <= 1'b0;
            bus.o_mem_to_reg <= 1'b0;
            bus.o_alu_src    <= 1'b0;
            bus.o_reg_dst    <= 1'b0;
            bus.o_alu_op     <= '0;
        end else begin
            bus.o_rs_data    <= rs_data;
            bus.o_rt_data    <= rt_data;
            bus.o_imm_ext    <= imm_ext;
            bus.o_rs         <= rs;
            bus.o_rt         <= rt;
            bus.o_rd         <= rd;
            bus.o_pc         <= bus.i_pc;
            bus.o_reg_write  <= dec_reg_write;
            bus.o_mem_read   <= dec_mem_read;
            bus.o_mem_write  <= dec_mem_write;
            bus.o_mem_to_reg <= dec_mem_to_reg;
            bus.o_alu_src    <= dec_alu_src;
            bus.o_reg_dst    <= dec_reg_dst;
            bus.o_alu_op     <= dec_alu_op;
        end
    end
endmodule

// File: tb/tb_instruction_decode_unit.sv
// Directed bench for the decode stage. Each cycle the stimulus pushes the
// expected same-cycle outputs and the expected next-cycle bundle; a monitor
// on the falling edge checks the combinational outputs of the current cycle
// and the bundle registered for the previous one.
module tb_instruction_decode_unit;
    logic clk;
    logic rst;

    instruction_decode_unit_if #(.NB_ADDR(5), .NB_DATA(32), .NB_REG(5)) bus ();

    instruction_decode_unit #(.NB_ADDR(5), .NB_DATA(32), .NB_REG(5)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl order: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    localparam logic [5:0] C_R  = 6'b100001;
    localparam logic [5:0] C_I  = 6'b100010;
    localparam logic [5:0] C_LW = 6'b110110;
    localparam logic [5:0] C_SW = 6'b001010;

    typedef struct {
        int          id;
        logic        stall;
        logic        pc_src;
        logic        chk_ba;
        logic [31:0] ba;
        logic        chk_fields;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs, rt, rd, pc;
        logic [5:0]  ctrl;
        logic [3:0]  alu;
        logic        halt;
    } exp_t;

    exp_t q[$];
    exp_t held;
    exp_t cur;
    logic held_v = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_id = 0;

    task automatic chk(input string name, input int id, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: actual=%0h required=%0h", name, id, act, req);
        end
    endtask

    function automatic exp_t bub(input logic halt);
        exp_t e;
        e = '{default: '0};
        e.chk_fields = 1'b1;
        e.halt = halt;
        return e;
    endfunction

    function automatic exp_t brn();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic exp_t bnd(input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] pc, input logic [5:0] ctrl, input logic [3:0] alu);
        exp_t e;
        e = '{default: '0};
        e.chk_fields = 1'b1;
        e.rs_d = rs_d; e.rt_d = rt_d; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd; e.pc = pc;
        e.ctrl = ctrl; e.alu = alu;
        return e;
    endfunction

    task automatic drive(input logic r, input logic [31:0] instr, input logic [4:0] pc,
                         input logic wb_we, input logic [4:0] wb_a, input logic [31:0] wb_d,
                         input logic ex_rw, input logic ex_mr, input logic [4:0] ex_d,
                         input logic mem_rw, input logic [4:0] mem_d);
        rst                 = r;
        bus.i_instruction   = instr;
        bus.i_pc            = pc;
        bus.i_wb_reg_write  = wb_we;
        bus.i_wb_addr       = wb_a;
        bus.i_wb_data       = wb_d;
        bus.i_ex_reg_write  = ex_rw;
        bus.i_ex_mem_read   = ex_mr;
        bus.i_ex_dst        = ex_d;
        bus.i_mem_reg_write = mem_rw;
        bus.i_mem_dst       = mem_d;
    endtask

    task automatic issue(input exp_t b, input logic stall, input logic pc_src,
                         input logic chk_ba, input logic [31:0] ba);
        exp_t e;
        e        = b;
        e.id     = cyc_id;
        e.stall  = stall;
        e.pc_src = pc_src;
        e.chk_ba = chk_ba;
        e.ba     = ba;
        q.push_back(e);
        cyc_id++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: previous cycle's bundle first, then this cycle's combinational outputs.
    always @(negedge clk) begin
        if (held_v) begin
            if (held.chk_fields) begin
                chk("bundle_data", held.id, {bus.o_rs_data, bus.o_rt_data, bus.o_imm_ext},
                    {held.rs_d, held.rt_d, held.imm});
                chk("bundle_idx", held.id, {bus.o_rs, bus.o_rt, bus.o_rd, bus.o_pc},
                    {held.rs, held.rt, held.rd, held.pc});
            end
            chk("bundle_ctrl", held.id,
                {bus.o_reg_write, bus.o_mem_read, bus.o_mem_write, bus.o_mem_to_reg,
                 bus.o_alu_src, bus.o_reg_dst, bus.o_alu_op},
                {held.ctrl, held.alu});
            chk("halt", held.id, bus.o_halt, held.halt);
            held_v = 1'b0;
        end
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk("stall", cur.id, bus.o_stall, cur.stall);
            chk("pc_source", cur.id, bus.o_pc_source, cur.pc_src);
            if (cur.chk_ba)
                chk("branch_addr", cur.id, bus.o_branch_addr, cur.ba);
            held   = cur;
            held_v = 1'b1;
        end
    end

    initial begin
        #5000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        // reset, squashed first slot, halt latch, halt-sticky bubble, mid-run reset
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);             issue(bub(0), 0, 0, 0, 0);
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);             issue(bub(0), 0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);             issue(bub(0), 0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);             issue(bub(1), 0, 0, 0, 0);
        drive(0, 32'h00600821, 1, 1, 6, 32'h1234, 0, 0, 0, 0, 0); issue(bub(1), 0, 0, 0, 0);
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);             issue(bub(0), 0, 0, 0, 0);
        drive(0, 32'h00000021, 0, 0, 0, 0, 0, 0, 0, 0, 0);      issue(bub(0), 0, 0, 0, 0);
        // R-type with WB bypass, then read of a reset-cleared register
        drive(0, 32'h00600821, 1, 1, 3, 32'h5, 0, 0, 0, 0, 0);
        issue(bnd(32'h5, 0, 32'h821, 3, 0, 1, 1, C_R, 0), 0, 0, 0, 0);
        drive(0, 32'h00663823, 2, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
        issue(bnd(32'h5, 0, 32'h3823, 3, 6, 7, 2, C_R, 1), 0, 0, 0, 0);
        // immediates: sign-extended ADDI (no bypass onto r0), zero-extended ORI/ANDI
        drive(0, 32'h2002FFFC, 3, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
        issue(bnd(0, 0, 32'hFFFF_FFFC, 0, 2, 31, 3, C_I, 0), 0, 0, 1, 32'hFFFF_FFFB);
        drive(0, 32'h3402FFFF, 4, 1, 5, 32'h100, 0, 0, 0, 0, 0);
        issue(bnd(0, 0, 32'h0000_FFFF, 0, 2, 31, 4, C_I, 3), 0, 0, 0, 0);
        drive(0, 32'h306500F0, 5, 1, 1, 32'h7, 0, 0, 0, 0, 0);
        issue(bnd(32'h5, 32'h100, 32'hF0, 3, 5, 0, 5, C_I, 2), 0, 0, 0, 0);
        // load-use on SW rt stalls; cleared next cycle; LW rt does not count as a source
        drive(0, 32'hACA40000, 6, 1, 2, 32'h7, 1, 1, 4, 0, 0);  issue(bub(0), 1, 0, 0, 0);
        drive(0, 32'hACA40000, 6, 1, 4, 32'hAA, 0, 0, 0, 0, 0);
        issue(bnd(32'h100, 32'hAA, 0, 5, 4, 0, 6, C_SW, 0), 0, 0, 0, 0);
        drive(0, 32'h8C260004, 7, 0, 0, 0, 1, 1, 6, 0, 0);
        issue(bnd(32'h7, 0, 32'h4, 1, 6, 0, 7, C_LW, 0), 0, 0, 0, 0);
        // BEQ taken, wrong-path squash beats load-use, BNE equal, BNE taken, squashed HALT
        drive(0, 32'h10220003, 8, 0, 0, 0, 0, 0, 0, 0, 0);      issue(brn(), 0, 1, 1, 32'h2);
        drive(0, 32'h00600821, 9, 0, 0, 0, 0, 1, 3, 0, 0);      issue(bub(0), 0, 0, 0, 0);
        drive(0, 32'h14220003, 9, 0, 0, 0, 0, 0, 0, 0, 0);      issue(brn(), 0, 0, 1, 32'h2);
        drive(0, 32'h14230005, 10, 0, 0, 0, 0, 0, 0, 0, 0);     issue(brn(), 0, 1, 1, 32'h4);
        drive(0, 32'h0, 11, 0, 0, 0, 0, 0, 0, 0, 0);            issue(bub(0), 0, 0, 0, 0);
        // branch operand hazards from MEM then EX, then resolution
        drive(0, 32'h10220003, 11, 0, 0, 0, 0, 0, 0, 1, 2);     issue(bub(0), 1, 0, 1, 32'h2);
        drive(0, 32'h10220003, 11, 0, 0, 0, 0, 0, 0, 1, 2);     issue(bub(0), 1, 0, 1, 32'h2);
        drive(0, 32'h10220003, 11, 0, 0, 0, 1, 0, 1, 0, 0);     issue(bub(0), 1, 0, 1, 32'h2);
        drive(0, 32'h10220003, 11, 0, 0, 0, 0, 0, 0, 0, 0);     issue(brn(), 0, 1, 1, 32'h2);
        drive(0, 32'h00600821, 12, 0, 0, 0, 0, 0, 0, 0, 0);     issue(bub(0), 0, 0, 0, 0);
        drive(0, 32'h00600821, 13, 0, 0, 0, 0, 0, 0, 0, 0);
        issue(bnd(32'h5, 0, 32'h821, 3, 0, 1, 13, C_R, 0), 0, 0, 0, 0);
        // unknown funct and unknown opcode give bubbles
        drive(0, 32'h00600820, 14, 0, 0, 0, 0, 0, 0, 0, 0);     issue(bub(0), 0, 0, 0, 0);
        drive(0, 32'hFC000001, 15, 0, 0, 0, 0, 0, 0, 0, 0);     issue(bub(0), 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("drain", cyc_id, {q.size(), held_v}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_decode_unit.md
Name: instruction_decode_unit

Overview:
- Second pipeline stage, directly downstream of instruction fetch.
- Consumes the registered fetched instruction and its PC+1, reads a 32-entry register file, and decodes control.
- Resolves BEQ/BNE early and returns the branch redirect to fetch.
- Detects hazards, drives the stall, and registers the ID/EX bundle.

Parameters:
NB_ADDR, 5, PC width (word address)
NB_DATA, 32, instruction/data width
NB_REG, 5, register index width; register file depth is 2**NB_REG

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_instruction  in  NB_DATA  fetched instruction from IF
i_pc  in  NB_ADDR  PC+1 of i_instruction
i_wb_reg_write  in  1  writeback enable
i_wb_addr  in  NB_REG  writeback register
i_wb_data  in  NB_DATA  writeback data
i_ex_reg_write, i_ex_mem_read  in  1 each  EX-stage controls
i_ex_dst  in  NB_REG  EX-stage destination
i_mem_reg_write  in  1  MEM-stage write enable
i_mem_dst  in  NB_REG  MEM-stage destination
o_pc_source  out  1  branch taken (combinational) to IF
o_branch_addr  out  NB_DATA  offset to IF (combinational)
o_stall  out  1  IF must hold PC and instruction register (combinational)
o_rs_data, o_rt_data, o_imm_ext  out  NB_DATA each  registered
o_rs, o_rt, o_rd  out  NB_REG each  registered
o_pc  out  NB_ADDR  registered
o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst  out  1 each  registered
o_alu_op  out  4  0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=SLT (registered)
o_halt  out  1  sticky halt (registered)

Behaviour:
- Reset: every registered output is 0, the register file is cleared, and valid_q and flush_q are 0.
- valid_q becomes 1 on the first cycle after reset deasserts. While valid_q=0 the instruction is squashed, because IF's reset value 0 must not halt.
- Decode (opcode [31:26], funct [5:0]):
  - R-type, opcode 0: ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, SLT 0x2A. These set reg_write=1 and reg_dst=1.
  - I-type: ADDI 0x08 (sign-extended imm); ANDI 0x0C and ORI 0x0D (zero-extended imm). These set alu_src=1 and reg_write=1.
  - LW 0x23: mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, ADD.
  - SW 0x2B: mem_write=1, alu_src=1, ADD.
  - BEQ 0x04 / BNE 0x05: all controls 0 in the bundle.
- Instruction value 0 is HALT. On a valid, unsquashed HALT, o_halt latches 1 until reset and all later bundles are bubbles.
- Unknown opcode or funct: bubble (all controls 0).
- Bubble: control bits 0; data and index fields are don't-care but driven 0.
- Register file:
  - Write on posedge when i_wb_reg_write=1 and i_wb_addr≠0. r0 always reads 0.
  - Read bypass: if the WB write targets rs or rt (nonzero) in the same cycle, the read returns i_wb_data.
- Branch:
  - Compare the bypassed rs and rt data; taken = (BEQ & equal) | (BNE & !equal), gated by valid, !squash and !stall.
  - o_branch_addr = sign_ext(imm16) − 1. IF adds it to its own PC+1, which is the branch PC+2, so the target lands at branch PC+1+imm.
- Flush: a taken branch sets flush_q for one cycle. The next instruction (the wrong-path slot) is squashed: bubble, no branch, no stall, no halt.
- Stall (o_stall=1, bundle is a bubble, inputs must be re-presented next cycle):
  - Load-use: i_ex_mem_read and i_ex_dst≠0 and i_ex_dst equals a used source (rs always; rt for R-type, SW, BEQ, BNE).
  - Branch: i_ex_reg_write with i_ex_dst equal to rs or rt (nonzero).
  - Branch: i_mem_reg_write with i_mem_dst equal to rs or rt (nonzero).
- Squash has priority over stall; stall has priority over branch and halt.
- Latency: the ID/EX bundle appears one cycle after the instruction is presented. Branch and stall outputs are same-cycle.
- Reset mid-operation: on the next edge all state returns to reset values, including o_halt and the register file.

Test Plan:
1. Reset held 2 cycles with i_instruction=0, then released → o_halt stays 0 in the first cycle (valid_q=0). A 0 presented in the second cycle sets o_halt=1, and it stays 1.
2. Write r3=0x0000_0005 via WB while presenting ADDU r1,r3,r0 (0x0060_0821) → next cycle: o_rs_data=5 (bypass), o_rd=1, o_reg_write=1, o_reg_dst=1, o_alu_op=0.
3. ADDI r2,r0,-4 (0x2002_FFFC) → o_imm_ext=0xFFFF_FFFC, o_alu_src=1. ORI r2,r0,0xFFFF → o_imm_ext=0x0000_FFFF, o_alu_op=3.
4. i_ex_mem_read=1, i_ex_dst=4 with SW r4,0(r5) presented → o_stall=1 and a bubble. With the EX inputs cleared the next cycle → o_stall=0 and o_mem_write=1.
5. r1=r2=7 with BEQ r1,r2,+3 presented → o_pc_source=1 and o_branch_addr=2. The next instruction (ADDU) is squashed to a bubble with o_pc_source=0. Repeat with BNE → o_pc_source=0.
6. BEQ r1,r2 with i_mem_reg_write=1, i_mem_dst=2 → o_stall=1 and o_pc_source=0 until the MEM condition clears.
